// File: rtl/unidade_multdiv.sv
`default_nettype none
// ============================================================================
//  Module      : unidade_multdiv
//  Description : Iterative MIPS multiply/divide unit with HI/LO registers.
//                MULT/MULTU by shift-add, DIV/DIVU by restoring division,
//                one iteration per clock over WIDTH cycles, busy/done
//                handshake, MTHI/MTLO writes while idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module unidade_multdiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_wr_hi,
    input  logic             i_wr_lo,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div0,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam logic [0:0]       c_IDLE      = 1'b0;
    localparam logic [0:0]       c_RUN       = 1'b1;
    localparam logic [CNT_W-1:0] c_LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic [CNT_W-1:0]   r_cnt;

    // Working register: upper half is the partial product / partial
    // remainder, lower half is the multiplier / dividend being consumed.
    logic [2*WIDTH-1:0] r_work;
    logic [WIDTH-1:0]   r_opnd;      // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0]   r_a_orig;    // raw dividend, returned in HI on divide-by-zero
    logic               r_is_div;
    logic               r_neg_q;     // negate product / quotient at the end
    logic               r_neg_r;     // negate remainder (follows dividend sign)
    logic               r_b_zero;

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_div0;

    logic               w_busy;
    logic               w_load;
    logic               w_last;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    logic [WIDTH:0]     w_add;
    logic [2*WIDTH-1:0] w_mul_step;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH-1:0]   w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_div_step;
    logic [2*WIDTH-1:0] w_work_step;

    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: a start is only honoured from IDLE, so a request
    // during the done cycle chains straight into a new operation.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (i_start) w_next_state = c_RUN;
            c_RUN:   if (w_last)  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // State-decoded control strobes
    always_comb begin
        w_busy = (r_state == c_RUN);
        w_load = (r_state == c_IDLE) && i_start;
        w_last = (r_state == c_RUN) && (r_cnt == c_LAST_ITER);
    end

    // Operand magnitudes for the signed variants (MULT/DIV have op[0]=0)
    always_comb begin
        w_signed = ~i_op[0];
        w_a_neg  = w_signed & i_a[WIDTH-1];
        w_b_neg  = w_signed & i_b[WIDTH-1];
        w_a_mag  = w_a_neg ? (-i_a) : i_a;
        w_b_mag  = w_b_neg ? (-i_b) : i_b;
    end

    // One iteration of shift-add multiply and of restoring divide
    always_comb begin
        w_add       = {1'b0, r_work[2*WIDTH-1:WIDTH]}
                    + (r_work[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
        w_mul_step  = {w_add, r_work[WIDTH-1:1]};

        // Partial remainder is always below the divisor, so the shifted
        // value fits in WIDTH+1 bits and the difference in WIDTH bits.
        w_shift     = {r_work[2*WIDTH-1:WIDTH], r_work[WIDTH-1]};
        w_ge        = (w_shift >= {1'b0, r_opnd});
        w_diff      = w_shift[WIDTH-1:0] - r_opnd;
        w_div_step  = w_ge ? {w_diff,              r_work[WIDTH-2:0], 1'b1}
                           : {w_shift[WIDTH-1:0],  r_work[WIDTH-2:0], 1'b0};

        w_work_step = r_is_div ? w_div_step : w_mul_step;
    end

    // Final HI/LO values, taken from the last iteration's output
    always_comb begin
        w_res_hi = '0;
        w_res_lo = '0;
        if (!r_is_div) begin
            {w_res_hi, w_res_lo} = r_neg_q ? (-w_work_step) : w_work_step;
        end else if (r_b_zero) begin
            w_res_hi = r_a_orig;
            w_res_lo = {WIDTH{1'b1}};
        end else begin
            w_res_lo = r_neg_q ? (-w_work_step[WIDTH-1:0]) : w_work_step[WIDTH-1:0];
            w_res_hi = r_neg_r ? (-w_work_step[2*WIDTH-1:WIDTH])
                               : w_work_step[2*WIDTH-1:WIDTH];
        end
    end

    // Operand capture on start, then one iteration per cycle while running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_work   <= '0;
            r_opnd   <= '0;
            r_a_orig <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
        end else if (w_load) begin
            r_cnt    <= '0;
            r_is_div <= i_op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_b_zero <= (i_b == '0);
            r_a_orig <= i_a;
            r_opnd   <= i_op[1] ? w_b_mag : w_a_mag;
            r_work   <= {{WIDTH{1'b0}}, (i_op[1] ? w_a_mag : w_b_mag)};
        end else if (w_busy) begin
            r_cnt    <= r_cnt + c_CNT_ONE;
            r_work   <= w_work_step;
        end
    end

    // HI/LO: result on completion, MTHI/MTLO only while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_last) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else if (!w_busy) begin
            if (i_wr_hi) r_hi <= i_wdata;
            if (i_wr_lo) r_lo <= i_wdata;
        end
    end

    // Single-cycle completion pulse with its divide-by-zero qualifier
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
            r_div0 <= 1'b0;
        end else begin
            r_done <= w_last;
            r_div0 <= w_last & r_is_div & r_b_zero;
        end
    end

    assign o_busy = w_busy;
    assign o_done = r_done;
    assign o_div0 = r_div0;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_unidade_multdiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unidade_multdiv
//  Description : Directed self-checking bench for unidade_multdiv.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unidade_multdiv;

    localparam logic [1:0] c_MULT  = 2'b00;
    localparam logic [1:0] c_MULTU = 2'b01;
    localparam logic [1:0] c_DIV   = 2'b10;
    localparam logic [1:0] c_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_pass  = 0;
    int n_total = 0;
    int lat;
    int nbusy;
    int done_seen;

    unidade_multdiv #(.WIDTH(32), .CNT_W(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (start),
        .i_op    (op),
        .i_a     (a),
        .i_b     (b),
        .i_wr_hi (wr_hi),
        .i_wr_lo (wr_lo),
        .i_wdata (wdata),
        .o_busy  (busy),
        .o_done  (done),
        .o_div0  (div0),
        .o_hi    (hi),
        .o_lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive a start for one edge (E0); returns #1 after E0
    task automatic issue(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 32'hA5A5_5A5A;   // operands may change after E0
        b     = 32'h0F0F_F0F0;
    endtask

    // Wait (bounded) for done; n counts edges, nb counts busy samples before done
    task automatic wait_done(output int n, output int nb);
        n  = 0;
        nb = 0;
        do begin
            if (busy) nb++;
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 100);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_div0", {31'b0, div0}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        rst = 1'b0;

        // MTHI then MTLO in IDLE
        wr_hi = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1;
        wr_hi = 1'b0;
        check("mthi_hi", hi, 32'h0000_1234);
        check("mthi_lo", lo, 32'd0);
        wr_lo = 1'b1; wdata = 32'h0000_5678;
        @(posedge clk); #1;
        wr_lo = 1'b0;
        check("mtlo_lo", lo, 32'h0000_5678);

        // Reset 10 cycles into MULT 7x6: everything clears, no done follows
        issue(c_MULT, 32'd7, 32'd6);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("midrst_no_done", done_seen, 32'd0);
        check("midrst_lo_after", lo, 32'd0);

        // MULTU max x max
        issue(c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, nbusy);
        check("multu_latency", lat, 32'd32);
        check("multu_busy_cycles", nbusy, 32'd32);
        check("multu_busy_at_done", {31'b0, busy}, 32'd0);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);
        check("multu_div0", {31'b0, div0}, 32'd0);
        @(posedge clk); #1;
        check("multu_done_pulse", {31'b0, done}, 32'd0);

        // MULT -3 x 5
        issue(c_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(lat, nbusy);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);

        // DIV -7 / 2
        issue(c_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, nbusy);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // DIVU 100 / 0
        issue(c_DIVU, 32'd100, 32'd0);
        wait_done(lat, nbusy);
        check("divu0_latency", lat, 32'd32);
        check("divu0_lo", lo, 32'hFFFF_FFFF);
        check("divu0_hi", hi, 32'd100);
        check("divu0_div0", {31'b0, div0}, 32'd1);
        @(posedge clk); #1;
        check("divu0_div0_clear", {31'b0, div0}, 32'd0);

        // DIV -7 / 0 returns the raw dividend in HI
        issue(c_DIV, 32'hFFFF_FFF9, 32'd0);
        wait_done(lat, nbusy);
        check("div0s_hi", hi, 32'hFFFF_FFF9);
        check("div0s_lo", lo, 32'hFFFF_FFFF);
        check("div0s_div0", {31'b0, div0}, 32'd1);

        // DIV overflow case
        issue(c_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, nbusy);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'd0);
        check("divovf_div0", {31'b0, div0}, 32'd0);

        // DIVU 100/7 with a start and MTLO attempted mid-run
        issue(c_DIVU, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1; op = c_MULTU; a = 32'd5; b = 32'd5;
        wr_lo = 1'b1; wdata = 32'h0000_DEAD;
        @(posedge clk); #1;
        start = 1'b0;
        wr_lo = 1'b0;
        check("busy_wrlo_ignored", lo, 32'h8000_0000);
        check("busy_midrun", {31'b0, busy}, 32'd1);
        wait_done(lat, nbusy);
        check("b2b1_latency_rest", lat, 32'd21);
        check("b2b1_hi", hi, 32'd2);
        check("b2b1_lo", lo, 32'd14);
        // second start during the done cycle
        issue(c_MULTU, 32'd3, 32'd4);
        check("b2b2_busy", {31'b0, busy}, 32'd1);
        check("b2b2_done_low", {31'b0, done}, 32'd0);
        wait_done(lat, nbusy);
        check("b2b2_latency", lat, 32'd32);
        check("b2b2_hi", hi, 32'd0);
        check("b2b2_lo", lo, 32'd12);

        // MTLO together with start: write at E0, result at E32
        wr_lo = 1'b1; wdata = 32'h0000_ABCD;
        issue(c_MULTU, 32'd2, 32'd3);
        wr_lo = 1'b0;
        check("wrlo_start_e0", lo, 32'h0000_ABCD);
        wait_done(lat, nbusy);
        check("wrlo_start_result_lo", lo, 32'd6);
        check("wrlo_start_result_hi", hi, 32'd0);

        // MTHI and MTLO together
        @(posedge clk); #1;
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h0000_55AA;
        @(posedge clk); #1;
        wr_hi = 1'b0; wr_lo = 1'b0;
        check("mt_both_hi", hi, 32'h0000_55AA);
        check("mt_both_lo", lo, 32'h0000_55AA);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/unidade_multdiv.md
Name: unidade_multdiv

Overview:
- Iterative multiply/divide unit fed directly by the register-file read ports (operand A = ReadData1, operand B = ReadData2).
- Executes MIPS MULT/MULTU/DIV/DIVU into internal HI/LO registers, and supports MTHI/MTLO writes.
- HI/LO are exposed to the writeback mux for MFHI/MFLO.
- Provides a busy/done handshake so control can stall the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration-counter width; must hold the value WIDTH.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, request a new operation; sampled only when busy=0.
- op, input, 2, 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a, input, WIDTH, operand A (multiplicand / dividend).
- b, input, WIDTH, operand B (multiplier / divisor).
- wr_hi, input, 1, MTHI write enable.
- wr_lo, input, 1, MTLO write enable.
- wdata, input, WIDTH, MTHI/MTLO data.
- busy, output, 1, operation in progress.
- done, output, 1, one-cycle pulse when HI/LO receive a result.
- div0, output, 1, valid with done; 1 when a DIV/DIVU had b=0.
- hi, output, WIDTH, HI register.
- lo, output, WIDTH, LO register.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, hi=0, lo=0, busy=0, done=0, div0=0, counter=0.
  - Any in-flight result is discarded.
- States: IDLE, RUN.
- IDLE:
  - start=1 at edge E0 latches a, b, op.
  - Signed ops (MULT, DIV) latch |a| and |b|, plus the result-sign bits.
  - State goes to RUN; busy=1 from E0.
- RUN:
  - One iteration per edge for exactly WIDTH edges (E1..E32); the counter increments each edge.
  - Multiply: shift-add on the 2*WIDTH unsigned product of the magnitudes.
  - Divide: restoring shift-subtract producing a WIDTH quotient and WIDTH remainder.
- Completion, at edge E32:
  - hi/lo are written, busy=0, done=1 for exactly one cycle, and the state returns to IDLE.
  - Latency: start sampled at E0 → result visible after E32; busy is high for 32 cycles.
  - A start asserted while done=1 is accepted (back-to-back operations).
  - start while busy=1 is ignored; control must hold start until busy=0.
- Results:
  - Multiply: {hi,lo} = full 64-bit product. MULT is two's-complement; negate the 64-bit magnitude if sign(a) XOR sign(b).
  - Divide: lo = quotient, hi = remainder.
    - DIV truncates toward zero; remainder takes the sign of the dividend.
    - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0 (no trap).
  - Divide by zero (b=0, DIV or DIVU):
    - Still takes 32 cycles.
    - lo=0xFFFFFFFF, hi=a (original, unsigned-unmodified value), div0=1 with done.
    - div0=0 for multiplies and nonzero divisors; div0 is 0 whenever done=0.
- MTHI/MTLO:
  - In IDLE, wr_hi/wr_lo load wdata at the next edge. Both asserted together load the same value into both.
  - Simultaneous start and wr_*: the write takes effect at E0, and the operation result overwrites it at E32.
  - While busy=1, wr_hi/wr_lo are ignored (control must stall).
- Output timing:
  - hi/lo are register outputs, stable between completion and MT* writes; they do not change during RUN.
  - Operands a/b may change freely after E0.

Test Plan:
- Reset mid-RUN (assert rst 10 cycles after start of MULT 7×6) → busy=0, done=0, hi=lo=0 immediately; no done pulse follows.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done exactly 32 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for 32 cycles.
- MULT a=-3 (0xFFFFFFFD), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 → lo=0xFFFFFFFF, hi=100, div0=1 for the single done cycle. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, div0=0.
- Back-to-back: start DIVU 100/7 with a second start (MULTU 3×4) asserted during the done cycle → first result hi=2, lo=14; second done 32 cycles later with hi=0, lo=12. A start pulsed mid-RUN is ignored.
- MTHI/MTLO:
  - wr_hi=1, wdata=0x1234 in IDLE → hi=0x1234 next edge.
  - wr_lo during busy → lo unchanged.
  - wr_lo together with start → lo=wdata at E0, then overwritten at E32.
